axis_tlast_framer: RTL

AXIS_TLAST_FRAMER -- requirements
Module: axis_tlast_framer

---
 rtl/axis_pkg.sv | 18 +
 rtl/axis_if.sv | 17 +
 rtl/axis_skid_buf.sv | 68 ++++++
 rtl/axis_tlast_framer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream TLAST framer: width defaults, the
// buffered beat type and the ingress FSM state encoding.
package axis_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] tdata;
    logic                  tlast;
  } axis_beat_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } framer_state_e;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle (data, valid, ready, last) with the usual
// master/slave views.
interface axis_if
  import axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: a registered output stage plus one overflow slot,
// with a registered upstream ready that is high whenever a slot will be free.
module axis_skid_buf #(
  parameter type beat_t = axis_pkg::axis_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t skid_beat;
  logic  skid_valid;
  beat_t out_beat_d;
  beat_t skid_beat_d;
  logic  out_valid_d;
  logic  skid_valid_d;
  logic  push;
  logic  pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // The output stage refills from the skid slot first so ordering is kept;
  // the skid slot only fills while the output stage is stalled.
  always_comb begin
    out_beat_d   = out_beat;
    out_valid_d  = out_valid;
    skid_beat_d  = skid_beat;
    skid_valid_d = skid_valid;
    if (pop || !out_valid) begin
      if (skid_valid) begin
        out_beat_d   = skid_beat;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_beat_d  = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_beat_d  = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat   <= '0;
      out_valid  <= 1'b0;
      skid_beat  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_beat   <= out_beat_d;
      out_valid  <= out_valid_d;
      skid_beat  <= skid_beat_d;
      skid_valid <= skid_valid_d;
      in_ready   <= !skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_tlast_framer.sv
// Re-frames an AXI-Stream into fixed-length packets by generating TLAST,
// honouring an upstream TLAST as an early end, and counting packets.
module axis_tlast_framer
  import axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  axis_if.slave             s_axis,
  axis_if.master            m_axis,
  output logic [31:0]       stat_pkt_cnt,
  output logic [15:0]       stat_early_cnt,
  output logic              busy
);

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tlast;
  } frame_beat_t;

  framer_state_e state;
  framer_state_e state_d;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] len_cfg;
  logic [LEN_W-1:0] cnt_inc;
  logic accept;
  logic tag_last;
  logic early;
  frame_beat_t in_beat;
  frame_beat_t out_beat;

  assign accept  = s_axis.tvalid & s_axis.tready;
  assign len_cfg = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
  assign cnt_inc = cnt + LEN_W'(1);
  assign busy    = (cnt != '0);

  // Length is latched on the first beat so later cfg changes only affect
  // the next packet; cnt_inc never exceeds len, so LEN_W bits suffice.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    len_d    = len;
    tag_last = 1'b0;
    early    = 1'b0;
    case (state)
      ST_IDLE: begin
        tag_last = (len_cfg == LEN_W'(1)) || s_axis.tlast;
        early    = s_axis.tlast && (len_cfg > LEN_W'(1));
        if (accept && !tag_last) begin
          state_d = ST_IN_PKT;
          cnt_d   = LEN_W'(1);
          len_d   = len_cfg;
        end
      end
      ST_IN_PKT: begin
        tag_last = (cnt_inc == len) || s_axis.tlast;
        early    = s_axis.tlast && (cnt_inc < len);
        if (accept) begin
          if (tag_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      len   <= len_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stat_pkt_cnt   <= '0;
      stat_early_cnt <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      if (accept && early && (stat_early_cnt != 16'hFFFF)) begin
        stat_early_cnt <= stat_early_cnt + 16'd1;
      end
    end
  end

  assign in_beat.tdata = s_axis.tdata;
  assign in_beat.tlast = tag_last;

  axis_skid_buf #(
    .beat_t (frame_beat_t)
  ) u_skid (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .in_beat   (in_beat),
    .in_valid  (s_axis.tvalid),
    .in_ready  (s_axis.tready),
    .out_beat  (out_beat),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tdata = out_beat.tdata;
  assign m_axis.tlast = out_beat.tlast;

endmodule
